// File: rtl/core_seq_ctrl.sv
// Sequencer that generates the core instruction stream for one 3x3 convolution tile:
// per-kij weight/activation load, execute and psum drain, then per-output accumulation.
module core_seq_ctrl #(
    parameter int unsigned ROW       = 8,
    parameter int unsigned COL       = 8,
    parameter int unsigned LEN_NIJ   = 36,
    parameter int unsigned NIJ_SQRT  = 6,
    parameter int unsigned LEN_KIJ   = 9,
    parameter int unsigned KIJ_SQRT  = 3,
    parameter int unsigned ONIJ_SQRT = 4,
    parameter int unsigned GAP       = 10,
    parameter logic [10:0] W_BASE    = 11'h400
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  mode_in,
    input  logic        ofifo_valid,
    output logic [33:0] inst,
    output logic [1:0]  mode,
    output logic        core_reset,
    output logic        sfp_valid,
    output logic [3:0]  onij,
    output logic        busy,
    output logic        done
);

    typedef enum logic [3:0] {
        StIdle, StKrst, StWl0, StWld, StGap, StAl0, StExec, StOwait, StOrd,
        StOrst, StArd, StOut, StDone
    } state_e;

    localparam logic [33:0] INST_IDLE = 34'h1_800C_0000;
    localparam int unsigned ACC = 33, CEN_P = 32, WEN_P = 31, CEN_X = 19;
    localparam int unsigned OFIFO_RD = 6, L0_RD = 3, L0_WR = 2, EXE = 1, LOAD = 0;

    localparam logic [6:0] COL_T     = 7'(COL);
    localparam logic [6:0] NIJ_T     = 7'(LEN_NIJ);
    localparam logic [6:0] KIJ_T     = 7'(LEN_KIJ);
    localparam logic [6:0] KSQ_T     = 7'(KIJ_SQRT);
    localparam logic [6:0] WLD_LAST  = 7'(COL - 1);
    localparam logic [6:0] GAP_LAST  = 7'(GAP - 1);
    localparam logic [6:0] EXEC_LAST = 7'(LEN_NIJ + ROW + COL - 1);
    localparam logic [3:0] KIJ_LAST  = 4'(LEN_KIJ - 1);
    localparam logic [3:0] O_LAST    = 4'(ONIJ_SQRT * ONIJ_SQRT - 1);
    localparam logic [3:0] OSQ_O     = 4'(ONIJ_SQRT);

    state_e      state_q, state_d;
    logic [6:0]  t_q, t_d;
    logic [3:0]  kij_q, kij_d;
    logic [3:0]  o_q, o_d;

    logic [33:0] inst_d;
    logic        core_reset_d, sfp_valid_d;
    logic [3:0]  onij_d;
    logic [6:0]  ki, kj;
    logic [3:0]  r, c;
    logic [10:0] ard_addr;

    always_comb begin
        state_d = state_q;
        t_d     = t_q + 7'd1;
        kij_d   = kij_q;
        o_d     = o_q;
        unique case (state_q)
            StIdle: begin
                t_d = '0;
                if (start) begin
                    state_d = StKrst;
                    kij_d   = '0;
                    o_d     = '0;
                end
            end
            StKrst: begin state_d = StWl0; t_d = '0; end
            StWl0:  if (t_q == COL_T)    begin state_d = StWld; t_d = '0; end
            StWld:  if (t_q == WLD_LAST) begin state_d = StGap; t_d = '0; end
            StGap:  if (t_q == GAP_LAST) begin state_d = StAl0; t_d = '0; end
            StAl0:  if (t_q == NIJ_T)    begin state_d = StExec; t_d = '0; end
            StExec: begin
                if (t_q == EXEC_LAST) begin
                    state_d = ofifo_valid ? StOrd : StOwait;
                    t_d     = '0;
                end
            end
            StOwait: begin
                t_d = '0;
                if (ofifo_valid) state_d = StOrd;
            end
            StOrd: begin
                if (t_q == NIJ_T) begin
                    t_d = '0;
                    if (kij_q == KIJ_LAST) begin
                        state_d = StOrst;
                    end else begin
                        state_d = StKrst;
                        kij_d   = kij_q + 4'd1;
                    end
                end
            end
            StOrst: begin state_d = StArd; t_d = '0; end
            StArd:  if (t_q == KIJ_T) begin state_d = StOut; t_d = '0; end
            StOut: begin
                t_d = '0;
                if (o_q == O_LAST) begin
                    state_d = StDone;
                end else begin
                    state_d = StOrst;
                    o_d     = o_q + 4'd1;
                end
            end
            StDone: begin state_d = StIdle; t_d = '0; end
            default: begin state_d = StIdle; t_d = '0; end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    assign ki = t_d / KSQ_T;
    assign kj = t_d % KSQ_T;
    assign r  = o_d / OSQ_O;
    assign c  = o_d % OSQ_O;
    assign ard_addr = 11'(t_d) * 11'(LEN_NIJ + 1) + (11'(r) + 11'(ki)) * 11'(NIJ_SQRT)
                    + 11'(c) + 11'(kj);

    always_comb begin
        inst_d       = INST_IDLE;
        core_reset_d = 1'b0;
        sfp_valid_d  = 1'b0;
        onij_d       = '0;
        unique case (state_d)
            StKrst, StOrst: core_reset_d = 1'b1;
            StWl0: begin
                if (t_d < COL_T) begin
                    inst_d[CEN_X] = 1'b0;
                    inst_d[17:7]  = W_BASE + 11'(kij_d) * 11'(COL) + 11'(t_d);
                end
                inst_d[L0_WR] = (t_d != '0);
            end
            StWld: begin
                inst_d[L0_RD] = 1'b1;
                inst_d[LOAD]  = 1'b1;
            end
            StAl0: begin
                if (t_d < NIJ_T) begin
                    inst_d[CEN_X] = 1'b0;
                    inst_d[17:7]  = 11'(t_d);
                end
                inst_d[L0_WR] = (t_d != '0);
            end
            StExec: begin
                inst_d[EXE]   = (t_d < NIJ_T);
                inst_d[L0_RD] = (t_d < NIJ_T);
            end
            StOrd: begin
                inst_d[OFIFO_RD] = 1'b1;
                inst_d[CEN_P]    = 1'b0;
                inst_d[WEN_P]    = 1'b0;
                inst_d[30:20]    = 11'(kij_d) * 11'(LEN_NIJ + 1) + 11'(t_d);
            end
            StArd: begin
                if (t_d < KIJ_T) begin
                    inst_d[CEN_P] = 1'b0;
                    inst_d[30:20] = ard_addr;
                end
                inst_d[ACC] = (t_d != '0);
            end
            StOut: begin
                sfp_valid_d = 1'b1;
                onij_d      = o_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            t_q        <= '0;
            kij_q      <= '0;
            o_q        <= '0;
            inst       <= INST_IDLE;
            mode       <= '0;
            core_reset <= 1'b0;
            sfp_valid  <= 1'b0;
            onij       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            t_q        <= t_d;
            kij_q      <= kij_d;
            o_q        <= o_d;
            inst       <= inst_d;
            core_reset <= core_reset_d;
            sfp_valid  <= sfp_valid_d;
            onij       <= onij_d;
            busy       <= (state_d != StIdle) && (state_d != StDone);
            done       <= (state_d == StDone);
            if (state_q == StIdle && start) mode <= mode_in;
        end
    end

endmodule
